hsv_axil_ram: RTL

HSV_AXIL_RAM -- requirements
Module: hsv_axil_ram

---
 rtl/hsv_core_pkg.sv | 32 +++
 rtl/hsv_axil_ram_mem.sv | 31 +++
 rtl/hsv_axil_ram.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Shared core types: data-memory request formats and AXI-Lite response codes.
package hsv_core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef logic [1:0] axi_resp_t;
    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        DMEM_SIZE_B = 2'd0,
        DMEM_SIZE_H = 2'd1,
        DMEM_SIZE_W = 2'd2
    } dmem_size_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
        logic              we;
        dmem_size_e        size;
    } dmem_req_t;

    // Write holder payload: address from AW, data/strobe from W.
    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [STRB_W-1:0] strb;
    } axil_wr_t;

endpackage

// File: rtl/hsv_axil_ram_mem.sv
// Single-port byte-enabled word storage with one-cycle registered read; not reset.
module hsv_axil_ram_mem
    import hsv_core_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_core,
    input  logic                           en,
    input  logic                           wr,
    input  logic [STRB_W-1:0]              be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [XLEN-1:0]                wdata,
    output logic [XLEN-1:0]                rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Write cycles leave rdata untouched so a pending read response stays stable.
    always_ff @(posedge clk_core) begin
        if (en && wr) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hsv_axil_ram.sv
// AXI-Lite slave RAM: independent AW/W holders, AR bypass issue, alternating
// read/write arbitration onto a single-ported storage array.
module hsv_axil_ram
    import hsv_core_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk_core,
    input  logic              rst_core_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [31:0]       araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    logic            live;
    logic            aw_full;
    logic            w_full;
    logic            ar_full;
    logic            prio_rd;
    logic            rd_err_q;
    axil_wr_t        wr_q;
    logic [31:0]     ar_addr_q;

    logic            b_block;
    logic            wr_req;
    logic            ar_hs;
    logic            rd_req;
    logic            rd_go;
    logic            wr_go;
    logic [31:0]     rd_addr;
    logic [31:0]     rd_off;
    logic [31:0]     wr_off;
    logic            rd_ok;
    logic            wr_ok;
    logic            mem_en;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]     mem_rdata;

    // Request eligibility and arbitration; AR may issue in its own handshake cycle.
    assign b_block = bvalid && !bready;
    assign wr_req  = aw_full && w_full && !b_block;
    assign ar_hs   = arvalid && arready;
    assign rd_req  = ar_full || ar_hs;
    assign rd_go   = rd_req && (!wr_req || prio_rd);
    assign wr_go   = wr_req && !rd_go;

    // A holder draining this cycle can accept a new beat, sustaining one write per cycle.
    assign awready = live && (!aw_full || wr_go);
    assign wready  = live && (!w_full || wr_go);
    assign arready = live && !ar_full && !rvalid;

    assign rd_addr  = ar_full ? ar_addr_q : araddr;
    assign rd_off   = rd_addr - BASE_ADDR;
    assign wr_off   = wr_q.addr - BASE_ADDR;
    assign rd_ok    = 33'(rd_off) < SPAN;
    assign wr_ok    = 33'(wr_off) < SPAN;
    assign mem_en   = rd_go || (wr_go && wr_ok);
    assign mem_addr = rd_go ? rd_off[IDX_W+1:2] : wr_off[IDX_W+1:2];

    assign rdata = (rvalid && !rd_err_q) ? mem_rdata : 32'h0;

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            live      <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            ar_full   <= 1'b0;
            prio_rd   <= 1'b1;
            wr_q      <= '0;
            ar_addr_q <= '0;
        end else begin
            live <= 1'b1;
            if (awvalid && awready) begin
                aw_full   <= 1'b1;
                wr_q.addr <= awaddr;
            end else if (wr_go) begin
                aw_full <= 1'b0;
            end
            if (wvalid && wready) begin
                w_full    <= 1'b1;
                wr_q.data <= wdata;
                wr_q.strb <= wstrb;
            end else if (wr_go) begin
                w_full <= 1'b0;
            end
            if (ar_hs && !rd_go) begin
                ar_full   <= 1'b1;
                ar_addr_q <= araddr;
            end else if (rd_go) begin
                ar_full <= 1'b0;
            end
            // Under contention the loser gets priority next time.
            if (rd_req && wr_req) begin
                prio_rd <= !rd_go;
            end
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_go) begin
                bvalid <= 1'b1;
                bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
            if (rd_go) begin
                rvalid   <= 1'b1;
                rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                rd_err_q <= !rd_ok;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    hsv_axil_ram_mem #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk_core (clk_core),
        .en       (mem_en),
        .wr       (wr_go),
        .be       (wr_q.strb),
        .addr     (mem_addr),
        .wdata    (wr_q.data),
        .rdata    (mem_rdata)
    );

endmodule
